// File: rtl/multi_fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: modular pointer add and lane-mask counting.
package multi_fifo_pkg;

    localparam int unsigned MAX_LANES = 32;

    // Modular add by compare-and-subtract; needs ptr < depth and inc <= depth.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (v[i]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Number of consecutive ones starting at bit 0, looking at the low w bits only.
    function automatic int unsigned leading_ones(input logic [MAX_LANES-1:0] v,
                                                 input int unsigned w);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (run && (i < w) && v[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs the first `limit` valid push lanes into consecutive slots, in ascending lane order.
module lane_compactor #(
    parameter int unsigned M  = 4,
    parameter int unsigned DW = 32,
    localparam int unsigned AW = $clog2(M + 1)
) (
    input  logic [M-1:0]    valid,
    input  logic [M*DW-1:0] data,
    input  logic [AW-1:0]   limit,
    output logic [M-1:0]    accept,
    output logic [M*DW-1:0] cdata,
    output logic [AW-1:0]   ccount
);

    logic [AW-1:0] rank [M];
    logic [AW-1:0] total;

    // Exclusive prefix sum of the valid mask gives each lane its output slot.
    always_comb begin
        total = '0;
        for (int unsigned j = 0; j < M; j++) begin
            rank[j] = total;
            total   = total + AW'(valid[j]);
        end
    end

    always_comb begin
        accept = '0;
        cdata  = '0;
        ccount = '0;
        for (int unsigned j = 0; j < M; j++) begin
            accept[j] = valid[j] && (rank[j] < limit);
        end
        for (int unsigned k = 0; k < M; k++) begin
            for (int unsigned j = 0; j < M; j++) begin
                if (accept[j] && (rank[j] == AW'(k))) begin
                    cdata[k*DW +: DW] = data[j*DW +: DW];
                end
            end
        end
        ccount = (total < limit) ? total : limit;
    end

endmodule

// File: rtl/multi_fifo_hs.sv
// Multi-lane FIFO: up to M compacted pushes and N in-order pops per cycle, any DEPTH.
module multi_fifo_hs
    import multi_fifo_pkg::*;
#(
    parameter int unsigned DW            = 32,
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned FULL_PUSH_POP = 1,
    parameter int unsigned POP_CLEAR     = 0,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [M-1:0]        push_valid,
    input  logic [M*DW-1:0]     push_data,
    output logic [M-1:0]        push_accept,
    output logic [N-1:0]        pop_valid,
    output logic [N*DW-1:0]     pop_data,
    input  logic [N-1:0]        pop_ready,
    input  logic                flush,
    output logic [CW-1:0]       count,
    output logic [CW-1:0]       free,
    output logic [DEPTH*DW-1:0] fifo_data,
    output logic [PW-1:0]       wptr,
    output logic [PW-1:0]       rptr
);

    localparam int unsigned AW = $clog2(M + 1);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   acc_limit;
    logic [AW-1:0]   acc_cnt;
    logic [M*DW-1:0] cdata;
    int unsigned     pop_cnt;
    int unsigned     req_cnt;
    int unsigned     room;

    always_comb begin
        pop_valid = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_valid[i] = (32'(count) > i);
        end
    end

    // Pop count is the handshake prefix; room may include this cycle's pops.
    always_comb begin
        pop_cnt   = leading_ones(32'(pop_ready & pop_valid), N);
        req_cnt   = popcount(32'(push_valid));
        room      = 32'(free) + ((FULL_PUSH_POP != 0) ? pop_cnt : 0);
        acc_limit = AW'((req_cnt < room) ? req_cnt : room);
        if (rst || flush) begin
            acc_limit = '0;
        end
    end

    lane_compactor #(
        .M  (M),
        .DW (DW)
    ) u_compact (
        .valid  (push_valid),
        .data   (push_data),
        .limit  (acc_limit),
        .accept (push_accept),
        .cdata  (cdata),
        .ccount (acc_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            free  <= CW'(DEPTH);
        end else begin
            rptr  <= PW'(ptr_add(32'(rptr), pop_cnt, DEPTH));
            wptr  <= PW'(ptr_add(32'(wptr), 32'(acc_cnt), DEPTH));
            count <= CW'(32'(count) + 32'(acc_cnt) - pop_cnt);
            free  <= CW'(32'(free) + pop_cnt - 32'(acc_cnt));
        end
    end

    // Pushes are assigned after pop clears so a reused slot keeps the new data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if (POP_CLEAR != 0) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[PW'(i)] <= '0;
                end
            end
        end else begin
            if (POP_CLEAR != 0) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < pop_cnt) begin
                        mem[PW'(ptr_add(32'(rptr), i, DEPTH))] <= '0;
                    end
                end
            end
            for (int unsigned k = 0; k < M; k++) begin
                if (k < 32'(acc_cnt)) begin
                    mem[PW'(ptr_add(32'(wptr), k, DEPTH))] <= cdata[k*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        fifo_data = '0;
        pop_data  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_data[i*DW +: DW] = mem[PW'(ptr_add(32'(rptr), i, DEPTH))];
        end
        for (int unsigned i = 0; i < N; i++) begin
            pop_data[i*DW +: DW] = fifo_data[i*DW +: DW];
        end
    end

`ifdef ASSERT_ON
    logic [N-1:0] pop_taken;

    always_comb begin
        pop_taken = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_taken[i] = (i < pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert ((pop_ready & pop_valid) == pop_taken)
                else $error("pop_ready is not a prefix of pop_valid");
        end
    end
`endif

endmodule

// File: tb/tb_multi_fifo_hs.sv
// Bench for multi_fifo_hs: two configurations checked every cycle against a queue model.
module tb_multi_fifo_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   pv_a, pr_a, pa_a, pval_a, pv_b, pr_b, pa_b, pval_b;
    logic [127:0] pd_a, pd_b, pod_a, pod_b;
    logic         fl_a, fl_b;
    logic [4:0]   cnt_a, free_a;
    logic [3:0]   wp_a, rp_a;
    logic [511:0] fd_a;
    logic [2:0]   cnt_b, free_b, wp_b, rp_b;
    logic [191:0] fd_b;

    multi_fifo_hs #(.DW(32), .M(4), .N(4), .DEPTH(16), .FULL_PUSH_POP(1), .POP_CLEAR(0)) dut_a (
        .clk(clk), .rst(rst), .push_valid(pv_a), .push_data(pd_a), .push_accept(pa_a),
        .pop_valid(pval_a), .pop_data(pod_a), .pop_ready(pr_a), .flush(fl_a),
        .count(cnt_a), .free(free_a), .fifo_data(fd_a), .wptr(wp_a), .rptr(rp_a));

    multi_fifo_hs #(.DW(32), .M(4), .N(4), .DEPTH(6), .FULL_PUSH_POP(0), .POP_CLEAR(1)) dut_b (
        .clk(clk), .rst(rst), .push_valid(pv_b), .push_data(pd_b), .push_accept(pa_b),
        .pop_valid(pval_b), .pop_data(pod_b), .pop_ready(pr_b), .flush(fl_b),
        .count(cnt_b), .free(free_b), .fifo_data(fd_b), .wptr(wp_b), .rptr(rp_b));

    // Reference model: contents as queues, pointers as plain modular integers.
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          rp_m[2];
    int          wp_m[2];
    int          p_m[2];
    logic [3:0]  acc_m[2];
    int          a_m[2];
    bit          clr_m[2];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic logic [31:0] q_get(input int d, input int i);
        return (d == 0) ? q_a[i] : q_b[i];
    endfunction

    task automatic eval(input int d);
        int           depth, cnt, p, s, r, a, k;
        bit           fpp, pc, run, clr;
        logic [3:0]   pv, pr, pval, acc, o_pa, o_pval;
        logic [511:0] exp_fd, mask, o_fd, o_pd, o_cnt, o_free, o_rp, o_wp;
        string        n;
        if (d == 0) begin
            depth = 16; fpp = 1; pc = 0; n = "a";
            pv = pv_a; pr = pr_a; clr = rst | fl_a;
            o_pa = pa_a; o_pval = pval_a; o_fd = 512'(fd_a); o_pd = 512'(pod_a);
            o_cnt = 512'(cnt_a); o_free = 512'(free_a); o_rp = 512'(rp_a); o_wp = 512'(wp_a);
        end else begin
            depth = 6; fpp = 0; pc = 1; n = "b";
            pv = pv_b; pr = pr_b; clr = rst | fl_b;
            o_pa = pa_b; o_pval = pval_b; o_fd = 512'(fd_b); o_pd = 512'(pod_b);
            o_cnt = 512'(cnt_b); o_free = 512'(free_b); o_rp = 512'(rp_b); o_wp = 512'(wp_b);
        end
        cnt = q_size(d);
        pval = '0;
        for (int i = 0; i < 4; i++) pval[i] = (i < cnt);
        p = 0;
        run = 1;
        for (int i = 0; i < 4; i++) begin
            if (run && pval[i] && pr[i]) p++;
            else run = 0;
        end
        s = depth - cnt + (fpp ? p : 0);
        r = $countones(pv);
        a = (r < s) ? r : s;
        if (clr) a = 0;
        acc = '0;
        k = 0;
        for (int j = 0; j < 4; j++) begin
            if (pv[j]) begin
                if (k < a) acc[j] = 1'b1;
                k++;
            end
        end
        exp_fd = '0;
        mask   = '0;
        for (int i = 0; i < depth; i++) begin
            if (i < cnt) begin
                exp_fd[i*32 +: 32] = q_get(d, i);
                mask[i*32 +: 32]   = '1;
            end else if (pc) begin
                mask[i*32 +: 32] = '1;
            end
        end
        check({n, ".push_accept"}, 512'(o_pa), 512'(acc));
        check({n, ".pop_valid"}, 512'(o_pval), 512'(pval));
        check({n, ".count"}, o_cnt, 512'(cnt));
        check({n, ".free"}, o_free, 512'(depth - cnt));
        check({n, ".rptr"}, o_rp, 512'(rp_m[d]));
        check({n, ".wptr"}, o_wp, 512'(wp_m[d]));
        check({n, ".fifo_data"}, o_fd & mask, exp_fd);
        check({n, ".pop_data"}, o_pd & 512'(mask[127:0]), 512'(exp_fd[127:0]));
        p_m[d] = p; a_m[d] = a; acc_m[d] = acc; clr_m[d] = clr;
    endtask

    task automatic update(input int d);
        int depth;
        logic [127:0] pd;
        depth = (d == 0) ? 16 : 6;
        pd = (d == 0) ? pd_a : pd_b;
        if (clr_m[d]) begin
            if (d == 0) q_a.delete(); else q_b.delete();
            rp_m[d] = 0;
            wp_m[d] = 0;
        end else begin
            for (int i = 0; i < p_m[d]; i++) begin
                if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
            end
            for (int j = 0; j < 4; j++) begin
                if (acc_m[d][j]) begin
                    if (d == 0) q_a.push_back(pd[j*32 +: 32]); else q_b.push_back(pd[j*32 +: 32]);
                end
            end
            rp_m[d] = (rp_m[d] + p_m[d]) % depth;
            wp_m[d] = (wp_m[d] + a_m[d]) % depth;
        end
    endtask

    task automatic cycle();
        #1;
        eval(0);
        eval(1);
        @(posedge clk);
        update(0);
        update(1);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [3:0] pva, input logic [3:0] pra, input logic fla,
                         input logic [3:0] pvb, input logic [3:0] prb, input logic flb);
        rst = r;
        pv_a = pva; pr_a = pra; fl_a = fla;
        pv_b = pvb; pr_b = prb; fl_b = flb;
        pd_a = {$urandom, $urandom, $urandom, $urandom};
        pd_b = {$urandom, $urandom, $urandom, $urandom};
        cycle();
    endtask

    logic [3:0] rpa, rpb;

    initial begin
        rst = 1'b1;
        pv_a = '0; pr_a = '0; fl_a = 1'b0; pd_a = '0;
        pv_b = '0; pr_b = '0; fl_b = 1'b0; pd_b = '0;
        rp_m[0] = 0; rp_m[1] = 0; wp_m[0] = 0; wp_m[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        //     rst   pv_a     pr_a     fl_a  pv_b     pr_b     fl_b
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 4'b1010, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0);
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0);
        drive(1'b0, 4'b0111, 4'b0011, 1'b0, 4'b1111, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b1101, 1'b0, 4'b0001, 4'b0011, 1'b0);
        drive(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 600; c++) begin
            rpa = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'((32'd1 << $urandom_range(0, 4)) - 32'd1);
            rpb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'((32'd1 << $urandom_range(0, 4)) - 32'd1);
            if ($urandom_range(0, 15) == 0) rpa = 4'($urandom);
            if ($urandom_range(0, 15) == 0) rpb = 4'($urandom);
            drive(1'b0, 4'($urandom), rpa, ($urandom_range(0, 31) == 0),
                  4'($urandom), rpb, ($urandom_range(0, 31) == 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
